// File: rtl/weight_read_sequencer.sv
// weight_read_sequencer
// Streams one input vector past a neuron's weight memory. While the vector
// is streaming, each accepted sample issues a read at the next weight address
// in the same cycle. The sample is delayed by one cycle so that it lines up
// with the memory's registered read data. The aligned (x, w) pair then goes
// to the MAC with first/last markers, and a done pulse follows each complete
// vector.
//
// Optional feature (macro BIAS_FETCH_EN): during the DRAIN cycle one extra
// read is issued at address numWeight. Its data is presented on bias, with
// bias_valid asserted, in the done cycle. This needs numWeight < 2**addressWidth.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           pulse: begin (or restart) a vector
//   in_valid/in_data  input sample stream
//   ren/raddr       weight memory read request (combinational)
//   wout            weight memory read data (1-cycle latency)
//   mac_valid/mac_x/mac_w/mac_first/mac_last  aligned pair to the MAC
//   busy            vector in progress (STREAM or DRAIN)
//   done            one-cycle pulse when the vector is complete
//   err_overrun     sticky: a sample arrived outside STREAM
//   bias_valid/bias (BIAS_FETCH_EN only) fetched bias word
module weight_read_sequencer #(
   parameter int numWeight    = 784,
   parameter int addressWidth = 10,
   parameter int dataWidth    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    in_valid,
   input  logic [dataWidth-1:0]    in_data,
   output logic                    ren,
   output logic [addressWidth:0]   raddr,
   input  logic [dataWidth-1:0]    wout,
   output logic                    mac_valid,
   output logic [dataWidth-1:0]    mac_x,
   output logic [dataWidth-1:0]    mac_w,
   output logic                    mac_first,
   output logic                    mac_last,
   output logic                    busy,
   output logic                    done,
   output logic                    err_overrun
`ifdef BIAS_FETCH_EN
   ,
   output logic                    bias_valid,
   output logic [dataWidth-1:0]    bias
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   localparam logic [addressWidth:0] LAST_IDX = (addressWidth+1)'(numWeight - 1);
`ifdef BIAS_FETCH_EN
   localparam logic [addressWidth:0] BIAS_ADDR = (addressWidth+1)'(numWeight);
`endif

   state_t                  state_r;
   logic [addressWidth:0]   count_r;
   logic [dataWidth-1:0]    x_r;
   logic                    v_r;
   logic                    first_r;
   logic                    last_r;
   logic                    done_r;
   logic                    err_r;
   logic                    accept_s;
`ifdef BIAS_FETCH_EN
   logic                    bias_valid_r;
`endif

   // Sample acceptance: start in the same cycle takes priority over in_valid.
   // Reset also masks acceptance so that ren stays low while rst is held.
   always_comb begin
      accept_s = in_valid && (state_r == STREAM) && !start && !rst;
   end

   // Read request: zero-latency address issue, so the data returns in step
   // with the delayed sample.
   always_comb begin
      ren   = 1'b0;
      raddr = '0;
      if (rst) begin
         ren   = 1'b0;
         raddr = '0;
      end else begin
         case (state_r)
            STREAM: begin
               ren   = accept_s;
               raddr = count_r;
            end
`ifdef BIAS_FETCH_EN
            DRAIN: begin
               ren   = 1'b1;
               raddr = BIAS_ADDR;
            end
`endif
            default: begin
               ren   = 1'b0;
               raddr = '0;
            end
         endcase
      end
   end

   // Sequencer FSM and sample/marker delay pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         count_r <= '0;
         x_r     <= '0;
         v_r     <= 1'b0;
         first_r <= 1'b0;
         last_r  <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               v_r     <= 1'b0;
               first_r <= 1'b0;
               last_r  <= 1'b0;
               done_r  <= 1'b0;
               if (start) begin
                  state_r <= STREAM;
                  count_r <= '0;
                  err_r   <= 1'b0;
               end else if (in_valid) begin
                  err_r <= 1'b1;
               end
            end
            STREAM: begin
               done_r <= 1'b0;
               if (start) begin
                  // Abort: restart the vector and drop any pending pair.
                  count_r <= '0;
                  v_r     <= 1'b0;
                  first_r <= 1'b0;
                  last_r  <= 1'b0;
                  err_r   <= 1'b0;
               end else if (in_valid) begin
                  x_r     <= in_data;
                  v_r     <= 1'b1;
                  first_r <= (count_r == '0);
                  last_r  <= (count_r == LAST_IDX);
                  if (count_r == LAST_IDX) begin
                     count_r <= '0;
                     state_r <= DRAIN;
                  end else begin
                     count_r <= count_r + 1'b1;
                  end
               end else begin
                  v_r     <= 1'b0;
                  first_r <= 1'b0;
                  last_r  <= 1'b0;
               end
            end
            DRAIN: begin
               // start is ignored here; the vector always completes with done.
               v_r     <= 1'b0;
               first_r <= 1'b0;
               last_r  <= 1'b0;
               done_r  <= 1'b1;
               state_r <= IDLE;
               if (in_valid) begin
                  err_r <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               count_r <= '0;
               v_r     <= 1'b0;
               first_r <= 1'b0;
               last_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

`ifdef BIAS_FETCH_EN
   // Bias word returns one cycle after the DRAIN read, i.e. in the done cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         bias_valid_r <= 1'b0;
      end else begin
         bias_valid_r <= (state_r == DRAIN);
      end
   end

   // Bias is the memory data, forced to zero outside its valid cycle.
   always_comb begin
      bias_valid = bias_valid_r;
      if (bias_valid_r) begin
         bias = wout;
      end else begin
         bias = {dataWidth{1'b0}};
      end
   end
`endif

   // Output mapping; the weight is a straight pass-through of the memory data.
   always_comb begin
      mac_valid   = v_r;
      mac_x       = x_r;
      mac_w       = wout;
      mac_first   = first_r;
      mac_last    = last_r;
      busy        = (state_r == STREAM) || (state_r == DRAIN);
      done        = done_r;
      err_overrun = err_r;
   end

endmodule

// File: tb/tb_weight_read_sequencer.sv
module tb_weight_read_sequencer;

   localparam int NW = 4;
   localparam int AW = 3;
   localparam int DW = 16;
`ifdef BIAS_FETCH_EN
   localparam bit BIAS = 1'b1;
`else
   localparam bit BIAS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, start, in_valid;
   logic [DW-1:0] in_data;
   logic          ren;
   logic [AW:0]   raddr;
   logic [DW-1:0] wout;
   logic          mac_valid, mac_first, mac_last, busy, done, err_overrun;
   logic [DW-1:0] mac_x, mac_w;
`ifdef BIAS_FETCH_EN
   logic          bias_valid;
   logic [DW-1:0] bias;
`endif

   weight_read_sequencer #(.numWeight(NW), .addressWidth(AW), .dataWidth(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .ren(ren), .raddr(raddr), .wout(wout),
      .mac_valid(mac_valid), .mac_x(mac_x), .mac_w(mac_w),
      .mac_first(mac_first), .mac_last(mac_last),
      .busy(busy), .done(done), .err_overrun(err_overrun)
`ifdef BIAS_FETCH_EN
      , .bias_valid(bias_valid), .bias(bias)
`endif
   );

   always #5 clk = ~clk;

   // Weight memory: synchronous read, addr n holds 10+n, addr 4 holds the bias.
   logic [DW-1:0] mem [0:15];
   always @(posedge clk) if (ren) wout <= mem[raddr];

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   logic          seen_ren;
   logic [AW:0]   seen_raddr;

   // Reference model: vector progress expressed as "samples taken" plus a
   // countdown of cycles since the last sample.
   bit            streaming;
   int            k;
   int            tail;   // 1: drain cycle next, 2: done cycle
   bit            m_valid, m_first, m_last, m_done, m_busy, m_err, m_bv;
   logic [DW-1:0] m_x, m_w;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle(input logic r, input logic s, input logic v, input logic [DW-1:0] d);
      logic        e_ren;
      logic [AW:0] e_raddr;
      rst = r; start = s; in_valid = v; in_data = d;
      #4;
      e_ren   = !r && ((streaming && v && !s) || (BIAS && tail == 1));
      e_raddr = r ? 4'd0 : streaming ? 4'(k) : (BIAS && tail == 1) ? 4'(NW) : 4'd0;
      seen_ren = ren; seen_raddr = raddr;
      chk("ren", 32'(ren), 32'(e_ren));
      chk("raddr", 32'(raddr), 32'(e_raddr));
      @(posedge clk); #1;
      if (r) begin
         streaming = 0; k = 0; tail = 0; m_err = 0; m_valid = 0; m_done = 0;
         m_bv = 0; m_x = '0; m_first = 0; m_last = 0;
      end else begin
         m_valid = 0; m_first = 0; m_last = 0;
         m_done = (tail == 1);
         m_bv = BIAS && (tail == 1);
         if (tail == 1) begin
            tail = 2;
            if (v) m_err = 1;
         end else begin
            tail = 0;
            if (streaming) begin
               if (s) k = 0;
               else if (v) begin
                  m_valid = 1; m_x = d; m_w = mem[k];
                  m_first = (k == 0); m_last = (k == NW - 1);
                  k++;
                  if (k == NW) begin streaming = 0; k = 0; tail = 1; end
               end
            end else if (s) begin
               streaming = 1; k = 0; m_err = 0;
            end else if (v) m_err = 1;
         end
      end
      m_busy = streaming || (tail == 1);
      if (done === 1'b1) done_cnt++;
      chk("mac_valid", 32'(mac_valid), 32'(m_valid));
      if (m_valid || r) begin
         chk("mac_x", 32'(mac_x), 32'(m_x));
         chk("mac_first", 32'(mac_first), 32'(m_first));
         chk("mac_last", 32'(mac_last), 32'(m_last));
      end
      if (m_valid) chk("mac_w", 32'(mac_w), 32'(m_w));
      chk("done", 32'(done), 32'(m_done));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("err_overrun", 32'(err_overrun), 32'(m_err));
`ifdef BIAS_FETCH_EN
      chk("bias_valid", 32'(bias_valid), 32'(m_bv));
      chk("bias", 32'(bias), m_bv ? 32'h00AB : 32'h0);
`endif
   endtask

   typedef struct {
      logic s, v; logic [DW-1:0] d;
      logic e_ren; logic [AW:0] e_raddr;
      logic e_mv; logic [DW-1:0] e_x, e_w;
      logic e_f, e_l, e_done, e_busy;
   } vec_t;
   vec_t tbl [7];

   initial begin
      int d0;
      for (int i = 0; i < 16; i++) mem[i] = 16'(10 + i);
      mem[4] = 16'h00AB;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
      streaming = 0; k = 0; tail = 0;

      //          s     v     d      ren   raddr mv    x      w       f     l     done  busy
      tbl[0] = '{1'b1, 1'b0, 16'd0, 1'b0, 4'd0, 1'b0, 16'd0, 16'd0,  1'b0, 1'b0, 1'b0, 1'b1};
      tbl[1] = '{1'b0, 1'b1, 16'd1, 1'b1, 4'd0, 1'b1, 16'd1, 16'd10, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[2] = '{1'b0, 1'b1, 16'd2, 1'b1, 4'd1, 1'b1, 16'd2, 16'd11, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{1'b0, 1'b1, 16'd3, 1'b1, 4'd2, 1'b1, 16'd3, 16'd12, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{1'b0, 1'b1, 16'd4, 1'b1, 4'd3, 1'b1, 16'd4, 16'd13, 1'b0, 1'b1, 1'b0, 1'b1};
`ifdef BIAS_FETCH_EN
      tbl[5] = '{1'b0, 1'b0, 16'd0, 1'b1, 4'd4, 1'b0, 16'd0, 16'd0,  1'b0, 1'b0, 1'b1, 1'b0};
`else
      tbl[5] = '{1'b0, 1'b0, 16'd0, 1'b0, 4'd0, 1'b0, 16'd0, 16'd0,  1'b0, 1'b0, 1'b1, 1'b0};
`endif
      tbl[6] = '{1'b0, 1'b0, 16'd0, 1'b0, 4'd0, 1'b0, 16'd0, 16'd0,  1'b0, 1'b0, 1'b0, 1'b0};

      @(posedge clk); #1;
      cycle(1'b1, 1'b0, 1'b0, 16'd0);
      cycle(1'b0, 1'b0, 1'b0, 16'd0);

      // Back-to-back vector against the table.
      for (int i = 0; i < 7; i++) begin
         cycle(1'b0, tbl[i].s, tbl[i].v, tbl[i].d);
         chk("tbl_ren", 32'(seen_ren), 32'(tbl[i].e_ren));
         chk("tbl_raddr", 32'(seen_raddr), 32'(tbl[i].e_raddr));
         chk("tbl_mac_valid", 32'(mac_valid), 32'(tbl[i].e_mv));
         if (tbl[i].e_mv) begin
            chk("tbl_mac_x", 32'(mac_x), 32'(tbl[i].e_x));
            chk("tbl_mac_w", 32'(mac_w), 32'(tbl[i].e_w));
            chk("tbl_mac_first", 32'(mac_first), 32'(tbl[i].e_f));
            chk("tbl_mac_last", 32'(mac_last), 32'(tbl[i].e_l));
         end
         chk("tbl_done", 32'(done), 32'(tbl[i].e_done));
         chk("tbl_busy", 32'(busy), 32'(tbl[i].e_busy));
      end

      // Same vector with 3-cycle gaps.
      cycle(1'b0, 1'b1, 1'b0, 16'd0);
      for (int i = 1; i <= NW; i++) begin
         cycle(1'b0, 1'b0, 1'b1, 16'(i));
         for (int g = 0; g < 3; g++) cycle(1'b0, 1'b0, 1'b0, 16'd0);
      end
      cycle(1'b0, 1'b0, 1'b0, 16'd0);

      // Overrun after done, cleared by start.
      cycle(1'b0, 1'b0, 1'b1, 16'd9);
      chk("ovr_err", 32'(err_overrun), 32'd1);
      chk("ovr_ren", 32'(seen_ren), 32'd0);
      chk("ovr_mac_valid", 32'(mac_valid), 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 16'd0);
      chk("ovr_clear", 32'(err_overrun), 32'd0);

      // Abort: 2 samples, restart, full vector, exactly one done.
      d0 = done_cnt;
      cycle(1'b0, 1'b0, 1'b1, 16'd21);
      cycle(1'b0, 1'b0, 1'b1, 16'd22);
      cycle(1'b0, 1'b1, 1'b1, 16'd99);
      chk("abort_drop", 32'(mac_valid), 32'd0);
      for (int i = 1; i <= NW; i++) begin
         cycle(1'b0, 1'b0, 1'b1, 16'(30 + i));
         if (i == 1) begin
            chk("abort_raddr0", 32'(seen_raddr), 32'd0);
            chk("abort_first", 32'(mac_first), 32'd1);
         end
      end
      for (int g = 0; g < 3; g++) cycle(1'b0, 1'b0, 1'b0, 16'd0);
      chk("abort_done_count", 32'(done_cnt - d0), 32'd1);

      // Reset mid-stream, then a full vector.
      cycle(1'b0, 1'b1, 1'b0, 16'd0);
      cycle(1'b0, 1'b0, 1'b1, 16'd5);
      cycle(1'b0, 1'b0, 1'b1, 16'd6);
      cycle(1'b1, 1'b0, 1'b1, 16'd7);
      chk("rst_ren", 32'(seen_ren), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mac_valid", 32'(mac_valid), 32'd0);
      chk("rst_mac_x", 32'(mac_x), 32'd0);
      d0 = done_cnt;
      cycle(1'b0, 1'b1, 1'b0, 16'd0);
      for (int i = 1; i <= NW; i++) cycle(1'b0, 1'b0, 1'b1, 16'(40 + i));
      for (int g = 0; g < 3; g++) cycle(1'b0, 1'b0, 1'b0, 16'd0);
      chk("rst_vector_done", 32'(done_cnt - d0), 32'd1);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         cycle($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
               $urandom_range(0, 9) < 6, 16'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/weight_read_sequencer.md
Name: weight_read_sequencer

Overview:
- Sequences reads of one neuron's weight BRAM/ROM while an input vector streams in.
- Issues `ren` and `raddr` in lock-step with `in_valid`, absorbing the 1-cycle read latency of the weight memory.
- Presents aligned (x, w) pairs to the neuron's MAC, with first/last markers and a `done` pulse per vector.
- Sits between the layer input stream and each neuron's weight memory plus multiply-accumulate.

Parameters:
- numWeight, 784, weights (inputs) per neuron; 1 ≤ numWeight ≤ 2**addressWidth.
- addressWidth, 10, weight memory address width; the address port is addressWidth+1 bits.
- dataWidth, 16, width of input samples and weights.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a new input vector.
- in_valid  input  1  in_data valid this cycle.
- in_data  input  dataWidth  input sample.
- ren  output  1  weight memory read enable.
- raddr  output  addressWidth+1  weight memory read address.
- wout  input  dataWidth  weight memory read data, valid 1 cycle after ren.
- mac_valid  output  1  mac_x/mac_w pair valid.
- mac_x  output  dataWidth  delayed input sample.
- mac_w  output  dataWidth  weight; equals wout (pass-through).
- mac_first  output  1  marks pair index 0 (MAC clears its accumulator).
- mac_last  output  1  marks pair index numWeight-1.
- busy  output  1  high in STREAM and DRAIN.
- done  output  1  single-cycle pulse when the vector is complete.
- err_overrun  output  1  sticky; in_valid seen outside STREAM.

Behaviour:
- Reset (synchronous, active-high, on rising clk): state=IDLE, count=0, all pipeline registers cleared. Output values during and after reset:
  - ren=0, raddr=0.
  - mac_valid=0, mac_first=0, mac_last=0, mac_x=0.
  - busy=0, done=0, err_overrun=0.
- States: IDLE, STREAM, DRAIN.
- IDLE:
  - raddr=0, ren=0.
  - start → STREAM, count←0, err_overrun←0.
- STREAM, address issue (combinational, zero latency):
  - ren = in_valid && state==STREAM && !start.
  - raddr = count.
- STREAM, capture (registered, 1-cycle latency): on each accepted in_valid:
  - x_d←in_data, v_d←1.
  - first_d←(count==0), last_d←(count==numWeight-1).
  - count←count+1.
- MAC outputs:
  - mac_valid=v_d, mac_x=x_d, mac_first=first_d, mac_last=last_d, mac_w=wout.
  - The pair for sample k therefore appears exactly 1 cycle after sample k is accepted.
- Gaps: in_valid low → ren=0, count holds, v_d←0. Gaps may be of any length.
- Last weight: accepting the sample with count==numWeight-1 → state←DRAIN, count←0 (wrap).
- DRAIN:
  - Lasts one cycle, during which mac_last is presented.
  - Next cycle: done=1 for one cycle, state←IDLE.
  - With last accepted at cycle T: mac_last at T+1, done at T+2.
- Overrun: in_valid while in IDLE or DRAIN → sample ignored, ren=0, err_overrun←1. Cleared only by start or rst.
- Start while STREAM (abort):
  - start has priority; in_valid in the same cycle is ignored.
  - count←0, v_d←0 (any pending pair is dropped), state stays STREAM.
  - No done pulse for the aborted vector.
- Start while DRAIN: ignored. The DRAIN→IDLE sequence completes and done still pulses.
- Start in the same cycle as done (IDLE transition cycle): accepted, enters STREAM next cycle.
- numWeight=1: the single pair carries both mac_first=1 and mac_last=1.
- busy = state is STREAM or DRAIN.

Optional Feature:
- Macro: BIAS_FETCH_EN.
- Requires numWeight < 2**addressWidth.
- When defined:
  - Adds outputs `bias_valid` (1) and `bias` (dataWidth).
  - In DRAIN: ren=1, raddr=numWeight.
  - Next cycle: bias_valid=1 and bias=wout, in the same cycle as done.
  - Reset values: bias_valid=0, bias=0.
- When undefined:
  - Neither port exists.
  - ren=0 in DRAIN.
  - Timing is identical to the defined case (done still at T+2).

Test Plan:
- numWeight=4, addressWidth=3. rst, then start, then 4 back-to-back in_valid with data 1,2,3,4; memory holds addr n = 10+n.
  - raddr 0,1,2,3 with ren=1.
  - mac pairs (1,10),(2,11),(3,12),(4,13) one cycle later.
  - mac_first on the first pair, mac_last on the fourth.
  - done 2 cycles after the 4th input; busy low afterwards.
- Same vector with 3-cycle gaps between samples → identical pairs; mac_valid only on the 4 pair cycles; count holds through gaps.
- After done, in_valid=1 with data 9 → err_overrun=1, ren=0, no mac_valid. A following start → err_overrun=0.
- start, 2 samples, start again, then 4 samples → raddr restarts at 0; mac_first on the first new pair; exactly one done.
- rst asserted mid-stream after 2 samples → next cycle all outputs at reset values; a following full vector completes normally.
- BIAS_FETCH_EN defined, memory addr 4 = 0x00AB → ren=1 with raddr=4 in DRAIN; bias_valid=1 with bias=0x00AB in the done cycle.
